// File: rtl/mult16_pkg.sv
// Shared widths, FSM states and the slice-beat record used by the
// slice-recombination stage.
package mult16_pkg;

  localparam int ACC_W   = 32;
  localparam int SLICE_W = 4;
  localparam int OFF_W   = 5;
  localparam int CNT_W   = 8;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [SLICE_W-1:0] data;
    logic [OFF_W-1:0]   off;
    logic               last;
  } beat_t;

endpackage

// File: rtl/mult16_shift_add.sv
// Combinational align-and-add: shifts one slice result to its column offset
// and adds it to the running accumulator.
module mult16_shift_add
  import mult16_pkg::*;
#(
  parameter int P_ACC_W   = ACC_W,
  parameter int P_SLICE_W = SLICE_W,
  parameter int P_OFF_W   = OFF_W
) (
  input  logic [P_ACC_W-1:0]   acc,
  input  logic [P_SLICE_W-1:0] data,
  input  logic [P_OFF_W-1:0]   off,
  output logic [P_ACC_W-1:0]   sum,
  output logic                 carry,
  output logic                 drop
);

  logic [P_ACC_W+P_SLICE_W-1:0] wide;
  logic [P_ACC_W-1:0]           term;
  logic [P_ACC_W:0]             full;
  logic [P_SLICE_W-1:0]         drop_bits;

  assign wide = {{P_ACC_W{1'b0}}, data} << off;
  assign term = wide[P_ACC_W-1:0];

  // A set slice bit whose weight lands at or beyond the accumulator MSB+1 is lost.
  genvar gi;
  generate
    for (gi = 0; gi < P_SLICE_W; gi++) begin : g_drop
      assign drop_bits[gi] = data[gi] && ((int'(off) + gi) >= P_ACC_W);
    end
  endgenerate

  assign drop         = |drop_bits;
  assign full         = {1'b0, acc} + {1'b0, term};
  assign sum          = full[P_ACC_W-1:0];
  assign carry        = full[P_ACC_W];

endmodule

// File: rtl/mult16_slice_accum.sv
// Accumulates tagged slice beats into a 32-bit product and hands the finished
// product to the consumer over valid/ready; one product is held at a time.
module mult16_slice_accum
  import mult16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SLICE_W-1:0] in_data,
  input  logic [OFF_W-1:0]   in_off,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_prod,
  output logic [CNT_W-1:0]   out_beats,
  output logic               out_ovf
);

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   beats_reg;
  logic               ovf_reg;

  beat_t              beat;
  logic [ACC_W-1:0]   sum;
  logic               carry;
  logic               drop;
  logic [CNT_W-1:0]   beats_next;
  logic               ovf_next;
  logic               accept;

  assign beat = '{data: in_data, off: in_off, last: in_last};

  mult16_shift_add u_shift_add (
    .acc   (acc_reg),
    .data  (beat.data),
    .off   (beat.off),
    .sum   (sum),
    .carry (carry),
    .drop  (drop)
  );

  assign in_ready   = (state_reg == ACC);
  assign accept     = in_valid && in_ready;
  // Beat count sticks at all-ones rather than wrapping.
  assign beats_next = (&beats_reg) ? beats_reg : beats_reg + 1'b1;
  assign ovf_next   = ovf_reg || carry || drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ACC;
      acc_reg   <= '0;
      beats_reg <= '0;
      ovf_reg   <= 1'b0;
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state_reg)
        ACC: begin
          if (accept) begin
            acc_reg   <= sum;
            beats_reg <= beats_next;
            ovf_reg   <= ovf_next;
            if (beat.last) begin
              out_prod  <= sum;
              out_beats <= beats_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              state_reg <= HOLD;
            end
          end
        end
        HOLD: begin
          // Output registers keep the released product; only valid drops.
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_reg   <= '0;
            beats_reg <= '0;
            ovf_reg   <= 1'b0;
            state_reg <= ACC;
          end
        end
        default: state_reg <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mult16_slice_accum.sv
// Directed-vector bench: the stimulus thread queues each expected product,
// a monitor thread pops and compares on every output handshake.
module tb_mult16_slice_accum;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [4:0]  in_off;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_prod;
  logic [7:0]  out_beats;
  logic        out_ovf;

  typedef struct {
    logic [31:0] prod;
    logic [7:0]  beats;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  mult16_slice_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_off    (in_off),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_beats (out_beats),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [7:0] b, input logic o);
    exp_t e;
    e.prod  = p;
    e.beats = b;
    e.ovf   = o;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the beat.
  task automatic send(input logic [3:0] d, input logic [4:0] o, input logic l);
    int n;
    n        = 0;
    in_data  = d;
    in_off   = o;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: act=in_ready_low req=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_off    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_prod",  64'(out_prod),  64'd0);
    chk("rst_out_beats", 64'(out_beats), 64'd0);
    chk("rst_out_ovf",   64'(out_ovf),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_product: act=0x%0h req=none", out_prod);
            end else begin
              e = sb.pop_front();
              chk("sb_prod",  64'(out_prod),  64'(e.prod));
              chk("sb_beats", 64'(out_beats), 64'(e.beats));
              chk("sb_ovf",   64'(out_ovf),   64'(e.ovf));
            end
          end
        end
      end
      begin : stimulus
        int n;
        logic [31:0] held;

        // Three beats recombine to 0x1FF; valid appears one cycle after last.
        push(32'h0000_01FF, 8'd1 + 8'd2, 1'b0);
        send(4'hF, 5'd0, 1'b0);
        send(4'hF, 5'd4, 1'b0);
        chk("pre_last_valid", 64'(out_valid), 64'd0);
        send(4'h1, 5'd8, 1'b1);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);

        // Single-beat products, second one drops bit 32.
        push(32'hA000_0000, 8'd1, 1'b0);
        send(4'hA, 5'd28, 1'b1);
        push(32'h2000_0000, 8'd1, 1'b1);
        send(4'h9, 5'd29, 1'b1);

        // Carry out of bit 31.
        push(32'h7000_0000, 8'd2, 1'b1);
        send(4'hF, 5'd28, 1'b0);
        send(4'h1, 5'd31, 1'b1);

        // 300 zero beats: counted, count saturates.
        push(32'h0, 8'd255, 1'b0);
        for (int i = 0; i < 299; i++) send(4'h0, 5'd0, 1'b0);
        send(4'h0, 5'd0, 1'b1);

        // Back-pressure: product held, pending beat not consumed.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        push(32'h0000_0012, 8'd1, 1'b0);
        send(4'h9, 5'd1, 1'b1);
        held     = out_prod;
        in_data  = 4'h5;
        in_off   = 5'd0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_in_ready",  64'(in_ready),  64'd0);
          chk("bp_out_valid", 64'(out_valid), 64'd1);
          chk("bp_out_prod",  64'(out_prod),  64'h12);
        end
        chk("bp_held_stable", 64'(held), 64'h12);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(32'h0000_0005, 8'd1, 1'b0);
        send(4'h5, 5'd0, 1'b1);

        // Reset in the middle of a product.
        @(posedge clk);
        #1;
        send(4'h3, 5'd0, 1'b0);
        send(4'h3, 5'd4, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_prod",  64'(out_prod),  64'd0);
        chk("mid_rst_out_beats", 64'(out_beats), 64'd0);
        chk("mid_rst_out_ovf",   64'(out_ovf),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'h0000_0006, 8'd1, 1'b0);
        send(4'h3, 5'd1, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
          @(posedge clk);
          n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
      end
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
